// File: rtl/chnl_pkg.sv
// Shared definitions for the buffered CHNL receiver: FSM state encoding and
// the words-per-beat helper.
package chnl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_RECV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int unsigned WORD_W = 32;

    function automatic int unsigned pw(input int unsigned pci_w);
        return pci_w / WORD_W;
    endfunction

endpackage

// File: rtl/chnl_fifo.sv
// Synchronous FIFO with extra-bit wrapping pointers and registered full/empty flags.
module chnl_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0] mem_r [DEPTH];
    logic [AW:0]  wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
    logic         full_r, empty_r, do_push_s, do_pop_s;

    // Next-pointer computation; flags are derived from next pointers so they register cleanly.
    always_comb begin
        do_push_s = push && !full_r;
        do_pop_s  = pop && !empty_r;
        wr_ptr_s  = wr_ptr_r + {{AW{1'b0}}, do_push_s};
        rd_ptr_s  = rd_ptr_r + {{AW{1'b0}}, do_pop_s};
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            full_r   <= (wr_ptr_s - rd_ptr_s) == FULL_CNT;
            empty_r  <= wr_ptr_s == rd_ptr_s;
        end
    end

    assign rdata = mem_r[rd_ptr_r[AW-1:0]];
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/chnl_repack.sv
// Width repacker: accepts IN words of W bits, emits OUT words of W bits, word 0 first.
module chnl_repack #(
    parameter int IN  = 1,
    parameter int OUT = 1,
    parameter int W   = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_val,
    output logic           in_rdy,
    input  logic [IN*W-1:0]  in_data,
    output logic           out_val,
    input  logic           out_rdy,
    output logic [OUT*W-1:0] out_data
);
    localparam int CAP = IN + OUT - 1;
    localparam int CW  = $clog2(CAP + 1);

    logic [CAP*W-1:0] buf_r, buf_s, shifted_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             pop_s, push_s;
    int               cnt_pop_s;

    assign out_val  = int'(cnt_r) >= OUT;
    assign out_data = buf_r[OUT*W-1:0];

    // Shift out the emitted word group, then append the incoming group behind what remains.
    always_comb begin
        pop_s     = out_val && out_rdy;
        cnt_pop_s = int'(cnt_r) - (pop_s ? OUT : 0);
        in_rdy    = (cnt_pop_s + IN) <= CAP;
        push_s    = in_val && in_rdy;
        shifted_s = pop_s ? (buf_r >> (OUT * W)) : buf_r;
        buf_s     = shifted_s;
        for (int k = 0; k < CAP; k++) begin
            if (push_s && k >= cnt_pop_s && k < cnt_pop_s + IN) begin
                buf_s[k*W +: W] = in_data[(k - cnt_pop_s)*W +: W];
            end else begin
                buf_s[k*W +: W] = shifted_s[k*W +: W];
            end
        end
        cnt_s = CW'(cnt_pop_s + (push_s ? IN : 0));
    end

    // Buffer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_r <= '0;
            cnt_r <= '0;
        end else begin
            buf_r <= buf_s;
            cnt_r <= cnt_s;
        end
    end

endmodule

// File: rtl/chnl_rx_buf.sv
// Buffered RIFFA/CHNL receiver: per-transaction FSM, length tracking with zero-padded
// final beat, beat FIFO and repacker. Optional counters under CHNL_RX_BUF_STATS_EN.
module chnl_rx_buf
    import chnl_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int RX_WIDTH         = 32,
    parameter int GCD              = 32,
    parameter int DEPTH            = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    output logic                        o_val,
    input  logic                        o_rdy,
    output logic [RX_WIDTH-1:0]         o_data,
    output logic                        busy,
    output logic                        err_short,
    output logic                        CHNL_RX_CLK,
    input  logic                        CHNL_RX,
    output logic                        CHNL_RX_ACK,
    input  logic                        CHNL_RX_LAST,
    input  logic [31:0]                 CHNL_RX_LEN,
    input  logic [30:0]                 CHNL_RX_OFF,
    input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
    input  logic                        CHNL_RX_DATA_VALID,
    output logic                        CHNL_RX_DATA_REN
`ifdef CHNL_RX_BUF_STATS_EN
    ,
    output logic [31:0]                 stat_txn,
    output logic [31:0]                 stat_beats
`endif
);
    localparam int PW = int'(pw(C_PCI_DATA_WIDTH));

    state_t                      state_r;
    logic [31:0]                 rem_r, dec_s;
    logic                        ack_r, busy_r, err_r;
    logic                        full_s, empty_s, ren_s, accept_s, last_s, rp_rdy_s;
    logic [C_PCI_DATA_WIDTH-1:0] beat_s, head_s;
    logic                        unused_s;

    assign unused_s         = ^{CHNL_RX_LAST, CHNL_RX_OFF};
    assign CHNL_RX_CLK      = clk_i;
    assign ren_s            = (state_r == S_RECV) && !full_s;
    assign CHNL_RX_DATA_REN = ren_s;
    assign accept_s         = CHNL_RX_DATA_VALID && ren_s;
    assign CHNL_RX_ACK      = ack_r;
    assign busy             = busy_r;
    assign err_short        = err_r;

    // Zero the words of the final beat that lie beyond the transaction length.
    always_comb begin
        last_s = rem_r <= 32'(PW);
        dec_s  = last_s ? rem_r : 32'(PW);
        beat_s = CHNL_RX_DATA;
        for (int w = 0; w < PW; w++) begin
            if (last_s && 32'(w) >= rem_r) begin
                beat_s[w*32 +: 32] = 32'd0;
            end else begin
                beat_s[w*32 +: 32] = CHNL_RX_DATA[w*32 +: 32];
            end
        end
    end

    // Transaction FSM with registered ACK, busy and short-transfer pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= S_IDLE;
            rem_r   <= 32'd0;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (CHNL_RX) begin
                        rem_r   <= CHNL_RX_LEN;
                        ack_r   <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= S_ACK;
                    end
                end
                S_ACK: begin
                    state_r <= (rem_r == 32'd0) ? S_DONE : S_RECV;
                end
                S_RECV: begin
                    if (accept_s) begin
                        rem_r <= rem_r - dec_s;
                    end
                    if (accept_s && last_s) begin
                        state_r <= S_DONE;
                    end else if (!CHNL_RX) begin
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (!CHNL_RX) begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    chnl_fifo #(
        .W     (C_PCI_DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (accept_s),
        .wdata (beat_s),
        .pop   (rp_rdy_s && !empty_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    chnl_repack #(
        .IN  (C_PCI_DATA_WIDTH / GCD),
        .OUT (RX_WIDTH / GCD),
        .W   (GCD)
    ) u_repack (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .in_val   (!empty_s),
        .in_rdy   (rp_rdy_s),
        .in_data  (head_s),
        .out_val  (o_val),
        .out_rdy  (o_rdy),
        .out_data (o_data)
    );

`ifdef CHNL_RX_BUF_STATS_EN
    // Free-running transaction and beat counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_txn   <= 32'd0;
            stat_beats <= 32'd0;
        end else begin
            if (state_r == S_ACK) begin
                stat_txn <= stat_txn + 32'd1;
            end
            if (accept_s) begin
                stat_beats <= stat_beats + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_chnl_rx_buf.sv
// Directed bench for chnl_rx_buf: a 32-bit PCIe instance (DEPTH=4) and a 64-bit one.
module tb_chnl_rx_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          checks = 0;
    int          passes = 0;

    logic        a_rx, a_valid, a_ren, a_ack, a_oval, a_ordy, a_busy, a_err, unused_a_clk;
    logic [31:0] a_len, a_data, a_odata;
    logic        b_rx, b_valid, b_ren, b_ack, b_oval, b_ordy, b_busy, b_err, unused_b_clk;
    logic [31:0] b_len, b_odata;
    logic [63:0] b_data;

    logic [31:0] a_q[$];
    logic [31:0] b_q[$];
    int a_beats = 0, a_ren_cyc = 0, a_acks = 0, a_ack_dbl = 0, a_errs = 0;
    int b_beats = 0;
    logic a_ack_prev = 1'b0;

    chnl_rx_buf #(.C_PCI_DATA_WIDTH(32), .RX_WIDTH(32), .GCD(32), .DEPTH(4)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .o_val(a_oval), .o_rdy(a_ordy), .o_data(a_odata),
        .busy(a_busy), .err_short(a_err), .CHNL_RX_CLK(unused_a_clk), .CHNL_RX(a_rx),
        .CHNL_RX_ACK(a_ack), .CHNL_RX_LAST(1'b0), .CHNL_RX_LEN(a_len), .CHNL_RX_OFF(31'd0),
        .CHNL_RX_DATA(a_data), .CHNL_RX_DATA_VALID(a_valid), .CHNL_RX_DATA_REN(a_ren)
    );

    chnl_rx_buf #(.C_PCI_DATA_WIDTH(64), .RX_WIDTH(32), .GCD(32), .DEPTH(4)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .o_val(b_oval), .o_rdy(b_ordy), .o_data(b_odata),
        .busy(b_busy), .err_short(b_err), .CHNL_RX_CLK(unused_b_clk), .CHNL_RX(b_rx),
        .CHNL_RX_ACK(b_ack), .CHNL_RX_LAST(1'b0), .CHNL_RX_LEN(b_len), .CHNL_RX_OFF(31'd0),
        .CHNL_RX_DATA(b_data), .CHNL_RX_DATA_VALID(b_valid), .CHNL_RX_DATA_REN(b_ren)
    );

    // Mid-cycle monitors: output words, accepted beats, ACK/err cycles.
    always @(negedge clk) begin
        if (a_oval && a_ordy) a_q.push_back(a_odata);
        if (b_oval && b_ordy) b_q.push_back(b_odata);
        if (a_valid && a_ren) a_beats <= a_beats + 1;
        if (b_valid && b_ren) b_beats <= b_beats + 1;
        if (a_ren) a_ren_cyc <= a_ren_cyc + 1;
        if (a_ack) a_acks <= a_acks + 1;
        if (a_ack && a_ack_prev) a_ack_dbl <= a_ack_dbl + 1;
        if (a_err) a_errs <= a_errs + 1;
        a_ack_prev <= a_ack;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Host side of instance A: present base+start+i until nbeats accepted or max_cyc spent.
    task automatic a_drive(input int start, input int nbeats, input int max_cyc,
                           input logic [31:0] base, output int got);
        logic acc;
        got = 0;
        a_valid = 1'b1;
        for (int c = 0; c < max_cyc && got < nbeats; c++) begin
            a_data = base + 32'(start + got);
            @(negedge clk);
            acc = a_valid && a_ren;
            @(posedge clk);
            #1;
            if (acc) got++;
        end
        a_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int got, got2, q0, n0, e0, r0, k0;
        int bgot;
        rst_n = 1'b0;
        a_rx = 1'b0; a_valid = 1'b0; a_len = 32'd0; a_data = 32'd0; a_ordy = 1'b1;
        b_rx = 1'b0; b_valid = 1'b0; b_len = 32'd0; b_data = 64'd0; b_ordy = 1'b1;
        cyc(2);
        check("rst_oval", a_oval, 1'b0);
        check("rst_ack", a_ack, 1'b0);
        check("rst_ren", a_ren, 1'b0);
        check("rst_busy", a_busy, 1'b0);
        check("rst_err", a_err, 1'b0);
        check("rst_b_oval", b_oval, 1'b0);
        rst_n = 1'b1;
        cyc(2);

        // LEN=4 basic transfer
        q0 = a_q.size(); n0 = a_acks; e0 = a_errs; k0 = a_beats;
        a_len = 32'd4; a_rx = 1'b1;
        a_drive(0, 4, 30, 32'h1000_0000, got);
        check("t1_got", got, 4);
        check("t1_busy_done", a_busy, 1'b1);
        cyc(3);
        check("t1_beats", a_beats - k0, 4);
        a_rx = 1'b0;
        cyc(2);
        check("t1_busy_idle", a_busy, 1'b0);
        cyc(4);
        check("t1_qsize", a_q.size() - q0, 4);
        for (int i = 0; i < 4; i++) check("t1_word", a_q[q0 + i], 32'h1000_0000 + 32'(i));
        check("t1_acks", a_acks - n0, 1);
        check("t1_errs", a_errs - e0, 0);

        // 64-bit beats, LEN=3: last beat padded with zero
        b_len = 32'd3; b_rx = 1'b1; b_valid = 1'b1; bgot = 0;
        for (int c = 0; c < 20 && bgot < 2; c++) begin
            b_data = (bgot == 0) ? {32'h2222_000B, 32'h1111_000A} : {32'hDEAD_BEEF, 32'h3333_000C};
            @(negedge clk);
            if (b_ren) bgot++;
            @(posedge clk);
            #1;
        end
        cyc(4);
        check("t2_beats", b_beats, 2);
        check("t2_ren_done", b_ren, 1'b0);
        b_valid = 1'b0; b_rx = 1'b0;
        cyc(6);
        check("t2_qsize", b_q.size(), 4);
        check("t2_w0", b_q[0], 32'h1111_000A);
        check("t2_w1", b_q[1], 32'h2222_000B);
        check("t2_w2", b_q[2], 32'h3333_000C);
        check("t2_w3", b_q[3], 32'h0000_0000);
        check("t2_busy", b_busy, 1'b0);

        // Backpressure: o_rdy=0, LEN=10 into a 4-deep FIFO
        a_ordy = 1'b0; q0 = a_q.size();
        a_len = 32'd10; a_rx = 1'b1;
        a_drive(0, 10, 20, 32'h3000_0000, got);
        check("t3_stall_beats", (got >= 4 && got <= 5), 1'b1);
        check("t3_ren_low", a_ren, 1'b0);
        check("t3_no_out", a_q.size() - q0, 0);
        a_ordy = 1'b1;
        a_drive(got, 10 - got, 40, 32'h3000_0000, got2);
        check("t3_total", got + got2, 10);
        a_rx = 1'b0;
        cyc(16);
        check("t3_qsize", a_q.size() - q0, 10);
        for (int i = 0; i < 10; i++) check("t3_word", a_q[q0 + i], 32'h3000_0000 + 32'(i));

        // LEN=0: ACK only
        q0 = a_q.size(); n0 = a_acks; r0 = a_ren_cyc; k0 = a_beats;
        a_len = 32'd0; a_rx = 1'b1; a_valid = 1'b1; a_data = 32'h4444_4444;
        cyc(6);
        check("t4_busy", a_busy, 1'b1);
        check("t4_acks", a_acks - n0, 1);
        check("t4_ren", a_ren_cyc - r0, 0);
        check("t4_beats", a_beats - k0, 0);
        a_valid = 1'b0; a_rx = 1'b0;
        cyc(2);
        check("t4_busy_idle", a_busy, 1'b0);
        cyc(3);
        check("t4_no_out", a_q.size() - q0, 0);

        // Short transfer: LEN=8, host drops after 3 beats, then LEN=2
        q0 = a_q.size(); e0 = a_errs;
        a_len = 32'd8; a_rx = 1'b1;
        a_drive(0, 3, 20, 32'h5000_0000, got);
        check("t5_got", got, 3);
        a_rx = 1'b0;
        cyc(6);
        check("t5_errs", a_errs - e0, 1);
        check("t5_busy", a_busy, 1'b0);
        check("t5_qsize", a_q.size() - q0, 3);
        for (int i = 0; i < 3; i++) check("t5_word", a_q[q0 + i], 32'h5000_0000 + 32'(i));
        q0 = a_q.size();
        a_len = 32'd2; a_rx = 1'b1;
        a_drive(0, 2, 20, 32'h6000_0000, got);
        a_rx = 1'b0;
        cyc(8);
        check("t5b_qsize", a_q.size() - q0, 2);
        for (int i = 0; i < 2; i++) check("t5b_word", a_q[q0 + i], 32'h6000_0000 + 32'(i));
        check("t5b_errs", a_errs - e0, 1);
        check("ack_single_cycle", a_ack_dbl, 0);

        // Reset mid-RECV with data buffered
        a_ordy = 1'b0;
        a_len = 32'd10; a_rx = 1'b1;
        a_drive(0, 3, 20, 32'h7000_0000, got);
        rst_n = 1'b0;
        #1;
        check("t6_ack", a_ack, 1'b0);
        check("t6_ren", a_ren, 1'b0);
        check("t6_oval", a_oval, 1'b0);
        check("t6_busy", a_busy, 1'b0);
        check("t6_err", a_err, 1'b0);
        a_rx = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        q0 = a_q.size();
        a_ordy = 1'b1;
        cyc(8);
        check("t6_no_stale", a_q.size() - q0, 0);
        check("t6_oval_after", a_oval, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
